// File: rtl/mig_pkg.sv
// Shared types, constants and literal helpers for the MIG sequential evaluator.
package mig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Literal 0 is const0; its complement (literal 1) is const1.
    localparam int unsigned LIT_CONST0 = 0;
    localparam int unsigned LIT_CONST1 = 1;

    // Literal width: signal index bits plus one complement bit.
    function automatic int unsigned lit_w(input int unsigned num_pi, input int unsigned max_nodes);
        return $clog2(1 + num_pi + max_nodes) + 1;
    endfunction

    // Complement flag of a literal.
    function automatic logic lit_comp(input logic [31:0] lit);
        return (lit & 32'd1) != 32'd0;
    endfunction

    // Signal index of a literal.
    function automatic logic [31:0] lit_idx(input logic [31:0] lit);
        return lit >> 1;
    endfunction

    // Build a literal from a signal index and complement flag.
    function automatic logic [31:0] make_lit(input logic [31:0] idx, input logic comp);
        return (idx << 1) | {31'd0, comp};
    endfunction

endpackage

// File: rtl/mig_maj3.sv
// Combinational majority of three complementable literals over a signal vector.
module mig_maj3
    import mig_pkg::*;
#(
    parameter int unsigned LIT_W = 6,
    parameter int unsigned NSIG  = 23
) (
    input  logic [LIT_W-1:0] lit_a,
    input  logic [LIT_W-1:0] lit_b,
    input  logic [LIT_W-1:0] lit_c,
    input  logic [NSIG-1:0]  sig,
    output logic             maj_c
);

    localparam int unsigned IDX_W = LIT_W - 1;
    localparam int unsigned PAD   = 1 << IDX_W;

    // Indices beyond the last node land on zero padding and read as 0.
    logic [PAD-1:0] sig_pad;
    logic           op_a;
    logic           op_b;
    logic           op_c;

    assign sig_pad = PAD'(sig);

    // Resolve each literal, then take the majority.
    always_comb begin
        op_a  = sig_pad[IDX_W'(lit_idx(32'(lit_a)))] ^ lit_comp(32'(lit_a));
        op_b  = sig_pad[IDX_W'(lit_idx(32'(lit_b)))] ^ lit_comp(32'(lit_b));
        op_c  = sig_pad[IDX_W'(lit_idx(32'(lit_c)))] ^ lit_comp(32'(lit_c));
        maj_c = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
    end

endmodule

// File: rtl/mig_seq_eval.sv
// Programmable majority-inverter-graph evaluator, one node per clock.
module mig_seq_eval
    import mig_pkg::*;
#(
    parameter  int unsigned NUM_PI    = 6,
    parameter  int unsigned MAX_NODES = 16,
    parameter  int unsigned NUM_PO    = 1,
    localparam int unsigned LIT_W     = lit_w(NUM_PI, MAX_NODES),
    localparam int unsigned ADDR_W    = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
    localparam int unsigned PO_IDX_W  = (NUM_PO > 1) ? $clog2(NUM_PO) : 1,
    localparam int unsigned NUM_W     = $clog2(MAX_NODES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [3*LIT_W-1:0]    prog_lit,
    input  logic                  prog_po_we,
    input  logic [PO_IDX_W-1:0]   prog_po_idx,
    input  logic [LIT_W-1:0]      prog_po_lit,
    input  logic [NUM_W-1:0]      prog_num,
    output logic                  prog_ready,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_PI-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_PO-1:0]     y
);

    localparam int unsigned NSIG = 1 + NUM_PI + MAX_NODES;

    state_t               state;
    state_t               state_d;
    logic [ADDR_W-1:0]    cnt;
    logic [NUM_W-1:0]     num;
    logic [3*LIT_W-1:0]   node_lit [MAX_NODES];
    logic [LIT_W-1:0]     po_lit [NUM_PO];
    logic [NUM_PI-1:0]    x_reg;
    logic [MAX_NODES-1:0] node_val;

    logic                 accept_c;
    logic                 last_c;
    logic                 node_c;
    logic [3*LIT_W-1:0]   cur_lit_c;
    logic [NSIG-1:0]      sig_c;
    logic [NSIG-1:0]      sig_nxt_c;
    logic [MAX_NODES-1:0] node_val_nxt_c;
    logic [NUM_PO-1:0]    y_nxt_c;

    // Handshake readiness is a pure IDLE decode, forced low while in reset.
    assign in_ready   = (state == IDLE) && !rst;
    assign prog_ready = (state == IDLE) && !rst;
    assign accept_c   = in_valid && in_ready;
    assign last_c     = (NUM_W'(cnt) == (num - NUM_W'(1)));

    // Current signal vector: const0, latched inputs, evaluated nodes.
    assign cur_lit_c      = node_lit[cnt];
    assign sig_c          = {node_val, x_reg, 1'b0};
    assign node_val_nxt_c = node_val | (MAX_NODES'(node_c) << cnt);

    // Vector that will be visible after this edge; feeds the output selection.
    always_comb begin
        sig_nxt_c = {node_val_nxt_c, x_reg, 1'b0};
        if (state == IDLE) begin
            sig_nxt_c = {{MAX_NODES{1'b0}}, in_data, 1'b0};
        end
    end

    mig_maj3 #(
        .LIT_W (LIT_W),
        .NSIG  (NSIG)
    ) u_node (
        .lit_a (cur_lit_c[LIT_W-1:0]),
        .lit_b (cur_lit_c[2*LIT_W-1:LIT_W]),
        .lit_c (cur_lit_c[3*LIT_W-1:2*LIT_W]),
        .sig   (sig_c),
        .maj_c (node_c)
    );

    for (genvar k = 0; k < NUM_PO; k++) begin : g_po
        mig_maj3 #(
            .LIT_W (LIT_W),
            .NSIG  (NSIG)
        ) u_po (
            .lit_a (po_lit[k]),
            .lit_b (po_lit[k]),
            .lit_c (po_lit[k]),
            .sig   (sig_nxt_c),
            .maj_c (y_nxt_c[k])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_d = (num == '0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                if (last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath, programming tables and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            num       <= '0;
            x_reg     <= '0;
            node_val  <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            for (int i = 0; i < MAX_NODES; i++) begin
                node_lit[i] <= '0;
            end
            for (int k = 0; k < NUM_PO; k++) begin
                po_lit[k] <= '0;
            end
        end else begin
            out_valid <= (state_d == DONE);
            if ((state != DONE) && (state_d == DONE)) begin
                y <= y_nxt_c;
            end
            if (state == IDLE) begin
                if (accept_c) begin
                    x_reg    <= in_data;
                    node_val <= '0;
                    cnt      <= '0;
                end
                if (prog_we) begin
                    for (int i = 0; i < MAX_NODES; i++) begin
                        if (prog_addr == ADDR_W'(i)) begin
                            node_lit[i] <= prog_lit;
                        end
                    end
                end
                if (prog_po_we) begin
                    for (int k = 0; k < NUM_PO; k++) begin
                        if (prog_po_idx == PO_IDX_W'(k)) begin
                            po_lit[k] <= prog_po_lit;
                        end
                    end
                    num <= (prog_num > NUM_W'(MAX_NODES)) ? NUM_W'(MAX_NODES) : prog_num;
                end
            end
            if (state == EVAL) begin
                node_val <= node_val_nxt_c;
                cnt      <= last_c ? '0 : cnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mig_seq_eval.sv
// Directed self-checking bench for mig_seq_eval.
module tb_mig_seq_eval;
    import mig_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [17:0] prog_lit;
    logic        prog_po_we;
    logic [0:0]  prog_po_idx;
    logic [5:0]  prog_po_lit;
    logic [4:0]  prog_num;
    logic        prog_ready;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  y;

    int ncmp  = 0;
    int nfail = 0;

    mig_seq_eval #(
        .NUM_PI    (6),
        .MAX_NODES (16),
        .NUM_PO    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_lit    (prog_lit),
        .prog_po_we  (prog_po_we),
        .prog_po_idx (prog_po_idx),
        .prog_po_lit (prog_po_lit),
        .prog_num    (prog_num),
        .prog_ready  (prog_ready),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y)
    );

    always #5 clk = ~clk;

    // Literal helpers: x_i is signal 1+i, node k is signal 7+k.
    function automatic logic [5:0] lx(input int i, input logic comp);
        return 6'(make_lit(32'(1 + i), comp));
    endfunction

    function automatic logic [5:0] ln(input int k, input logic comp);
        return 6'(make_lit(32'(7 + k), comp));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_node(input int k, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        prog_we   = 1'b1;
        prog_addr = 4'(k);
        prog_lit  = {c, b, a};
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic prog_po(input logic [5:0] l, input int n);
        prog_po_we  = 1'b1;
        prog_po_idx = 1'b0;
        prog_po_lit = l;
        prog_num    = 5'(n);
        tick();
        prog_po_we  = 1'b0;
    endtask

    task automatic start_vec(input logic [5:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from acceptance edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        repeat (2) tick();
        ncmp++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        ncmp++; if (prog_ready !== 1'b0) begin nfail++; $display("FAIL rst_prog_ready got %b want 0", prog_ready); end
        ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        ncmp++; if (y !== 1'b0) begin nfail++; $display("FAIL rst_y got %b want 0", y); end
        rst = 1'b0;
        tick();
        prog_node(0, lx(0, 1'b0), lx(1, 1'b0), lx(2, 1'b0));
        prog_po(lx(0, 1'b0), 16);
        start_vec(6'b000111);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ncmp++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL midrst_in_ready cyc %0d got %b want 0", i, in_ready); end
            ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_out_valid cyc %0d got %b want 0", i, out_valid); end
            ncmp++; if (y !== 1'b0) begin nfail++; $display("FAIL midrst_y cyc %0d got %b want 0", i, y); end
        end
        rst = 1'b0;
        #1;
        ncmp++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL postrst_in_ready got %b want 1", in_ready); end
        start_vec(6'b000111);
        wait_valid(lat);
        ncmp++; if (lat != 1) begin nfail++; $display("FAIL postrst_latency got %0d want 1", lat); end
        ncmp++; if (y !== 1'b0) begin nfail++; $display("FAIL postrst_y got %b want 0", y); end
        finish_out();
    endtask

    task automatic test_single_node();
        int         lat;
        logic [5:0] din [2] = '{6'b000011, 6'b000001};
        logic       exp [2] = '{1'b1, 1'b0};
        prog_node(0, lx(0, 1'b0), lx(1, 1'b0), lx(2, 1'b0));
        prog_po(ln(0, 1'b0), 1);
        for (int i = 0; i < 2; i++) begin
            start_vec(din[i]);
            wait_valid(lat);
            ncmp++; if (lat != 2) begin nfail++; $display("FAIL single_latency vec %0d got %0d want 2", i, lat); end
            ncmp++; if (y !== exp[i]) begin nfail++; $display("FAIL single_y vec %0d got %b want %b", i, y, exp[i]); end
            finish_out();
        end
    endtask

    task automatic test_complement_const();
        int         lat;
        logic [5:0] din [3] = '{6'b000001, 6'b000011, 6'b000001};
        logic       inv [3] = '{1'b0, 1'b0, 1'b1};
        logic       exp [3] = '{1'b1, 1'b0, 1'b0};
        prog_node(0, lx(0, 1'b0), lx(1, 1'b1), 6'(LIT_CONST0));
        for (int i = 0; i < 3; i++) begin
            prog_po(ln(0, inv[i]), 1);
            start_vec(din[i]);
            wait_valid(lat);
            ncmp++; if (y !== exp[i]) begin nfail++; $display("FAIL compl_y vec %0d got %b want %b", i, y, exp[i]); end
            finish_out();
        end
    endtask

    task automatic test_depth();
        int         lat;
        logic [5:0] din [3] = '{6'b001000, 6'b000001, 6'b001001};
        logic       exp [3] = '{1'b0, 1'b1, 1'b1};
        prog_node(0, lx(0, 1'b0), lx(0, 1'b0), lx(3, 1'b0));
        for (int k = 1; k < 16; k++) begin
            prog_node(k, ln(k - 1, 1'b0), ln(k - 1, 1'b0), lx(3, 1'b0));
        end
        prog_po(ln(15, 1'b0), 16);
        for (int i = 0; i < 3; i++) begin
            start_vec(din[i]);
            wait_valid(lat);
            ncmp++; if (lat != 17) begin nfail++; $display("FAIL depth_latency vec %0d got %0d want 17", i, lat); end
            ncmp++; if (y !== exp[i]) begin nfail++; $display("FAIL depth_y vec %0d got %b want %b", i, y, exp[i]); end
            finish_out();
        end
        prog_node(0, ln(5, 1'b0), ln(5, 1'b0), lx(0, 1'b0));
        start_vec(6'b001001);
        wait_valid(lat);
        ncmp++; if (y !== 1'b0) begin nfail++; $display("FAIL fwdref_y got %b want 0", y); end
        finish_out();
    endtask

    task automatic test_backpressure();
        int         lat;
        logic [5:0] din [3] = '{6'b000111, 6'b000011, 6'b000001};
        logic       exp [3] = '{1'b1, 1'b1, 1'b0};
        prog_node(0, lx(0, 1'b0), lx(1, 1'b0), lx(2, 1'b0));
        prog_po(ln(0, 1'b0), 1);
        start_vec(6'b000111);
        wait_valid(lat);
        ncmp++; if (y !== 1'b1) begin nfail++; $display("FAIL bp_first_y got %b want 1", y); end
        in_valid    = 1'b1;
        in_data     = 6'b000000;
        prog_we     = 1'b1;
        prog_addr   = 4'd0;
        prog_lit    = 18'd0;
        prog_po_we  = 1'b1;
        prog_po_lit = 6'(LIT_CONST0);
        prog_num    = 5'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            ncmp++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL bp_out_valid cyc %0d got %b want 1", i, out_valid); end
            ncmp++; if (y !== 1'b1) begin nfail++; $display("FAIL bp_y cyc %0d got %b want 1", i, y); end
            ncmp++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
            ncmp++; if (prog_ready !== 1'b0) begin nfail++; $display("FAIL bp_prog_ready cyc %0d got %b want 0", i, prog_ready); end
        end
        in_valid   = 1'b0;
        prog_we    = 1'b0;
        prog_po_we = 1'b0;
        finish_out();
        ncmp++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            start_vec(din[i]);
            wait_valid(lat);
            ncmp++; if (lat != 2) begin nfail++; $display("FAIL bp_table_latency vec %0d got %0d want 2", i, lat); end
            ncmp++; if (y !== exp[i]) begin nfail++; $display("FAIL bp_table_y vec %0d got %b want %b", i, y, exp[i]); end
            finish_out();
        end
    endtask

    task automatic test_zero_nodes();
        int         lat;
        logic [5:0] pol [6] = '{6'd46, 6'd47, 6'd63, 6'd62, 6'd12, 6'd14};
        logic       exp [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        prog_po(6'(LIT_CONST1), 0);
        start_vec(6'b000000);
        wait_valid(lat);
        ncmp++; if (lat != 1) begin nfail++; $display("FAIL zero_latency got %0d want 1", lat); end
        ncmp++; if (y !== 1'b1) begin nfail++; $display("FAIL zero_y got %b want 1", y); end
        for (int i = 0; i < 3; i++) begin
            finish_out();
            ncmp++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL b2b_in_ready rnd %0d got %b want 1", i, in_ready); end
            ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL b2b_idle_valid rnd %0d got %b want 0", i, out_valid); end
            start_vec(6'(i));
            ncmp++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL b2b_out_valid rnd %0d got %b want 1", i, out_valid); end
            ncmp++; if (y !== 1'b1) begin nfail++; $display("FAIL b2b_y rnd %0d got %b want 1", i, y); end
        end
        finish_out();
        for (int i = 0; i < 6; i++) begin
            prog_po(pol[i], 0);
            start_vec(6'b100000);
            wait_valid(lat);
            ncmp++; if (y !== exp[i]) begin nfail++; $display("FAIL polit_y lit %0d got %b want %b", pol[i], y, exp[i]); end
            finish_out();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_lit    = '0;
        prog_po_we  = 1'b0;
        prog_po_idx = '0;
        prog_po_lit = '0;
        prog_num    = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        test_reset();
        test_single_node();
        test_complement_const();
        test_depth();
        test_backpressure();
        test_zero_nodes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
